ofdm_bin_serializer: RTL

//   Downstream of the 16-point OFDM FFT. Captures all N_BINS complex output bins on the
//   FFT's cycle-done pulse and streams them out one bin per accepted beat on a

---
 rtl/ofdm_pkg.sv | 22 ++
 rtl/ofdm_bin_buffer.sv | 50 +++++
 rtl/ofdm_bin_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_pkg
//   Shared constants and types for the OFDM bin serializer slice.
//   WORD_SIZE : width of each re/im sample
//   N_BINS    : bins per FFT frame
//   IDX_W     : width of a bin index (2**IDX_W >= N_BINS)
//   CNT_W     : width of the completed-frame counter
//   state_t   : serializer FSM states
// ---------------------------------------------------------------------------
package ofdm_pkg;

    localparam int WORD_SIZE = 16;
    localparam int N_BINS    = 16;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/ofdm_bin_buffer.sv
// ---------------------------------------------------------------------------
// ofdm_bin_buffer
//   N_BINS x (2*WORD_SIZE) register file holding one FFT frame.
//   All bins are written in parallel on the capture strobe; one bin is read
//   combinationally by index.
// Ports
//   clk      in  clock
//   rst      in  synchronous active-high reset, clears every entry
//   capture  in  load all bins from bins_re / bins_im
//   bins_re  in  packed real parts, bin k at [k*WORD_SIZE +: WORD_SIZE]
//   bins_im  in  packed imaginary parts, same packing
//   rd_idx   in  bin to read
//   rd_re    out real part of bin rd_idx
//   rd_im    out imaginary part of bin rd_idx
// ---------------------------------------------------------------------------
module ofdm_bin_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int N_BINS    = 16,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [N_BINS*WORD_SIZE-1:0]   bins_re,
    input  logic [N_BINS*WORD_SIZE-1:0]   bins_im,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic signed [WORD_SIZE-1:0]   rd_re,
    output logic signed [WORD_SIZE-1:0]   rd_im
);

    // Each entry packs {im, re}.
    logic [2*WORD_SIZE-1:0] mem [N_BINS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_BINS; k++) begin
                mem[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N_BINS; k++) begin
                mem[k] <= {bins_im[k*WORD_SIZE +: WORD_SIZE],
                           bins_re[k*WORD_SIZE +: WORD_SIZE]};
            end
        end
    end

    assign rd_re = mem[rd_idx][WORD_SIZE-1:0];
    assign rd_im = mem[rd_idx][2*WORD_SIZE-1:WORD_SIZE];

endmodule

// File: rtl/ofdm_bin_serializer.sv
// ---------------------------------------------------------------------------
// ofdm_bin_serializer
//   Captures a complete FFT frame on i_fft_done and streams it out one bin
//   per accepted beat (valid/ready), bin 0 first. A frame arriving while the
//   previous one is still draining is dropped and flagged on o_overflow,
//   except when it coincides with the final-beat transfer, in which case it
//   is taken back-to-back without an idle cycle.
// Ports
//   i_clk        in  clock, rising edge
//   i_rst        in  synchronous active-high reset
//   i_fft_done   in  one-cycle pulse: i_bins_* hold a full frame
//   i_bins_re    in  packed real parts, bin k at [k*WORD_SIZE +: WORD_SIZE]
//   i_bins_im    in  packed imaginary parts, same packing
//   i_ready      in  consumer accepts the current beat
//   o_valid      out beat valid
//   o_re/o_im    out sample of bin o_idx
//   o_idx        out bin index of the current beat
//   o_last       out high on the bin N_BINS-1 beat
//   o_busy       out a frame is held and not yet fully drained
//   o_overflow   out sticky dropped-frame flag, cleared only by reset
//   o_frame_cnt  out frames fully drained, wraps
// ---------------------------------------------------------------------------
module ofdm_bin_serializer #(
    parameter int WORD_SIZE = ofdm_pkg::WORD_SIZE,
    parameter int N_BINS    = ofdm_pkg::N_BINS,
    parameter int IDX_W     = ofdm_pkg::IDX_W,
    parameter int CNT_W     = ofdm_pkg::CNT_W
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_fft_done,
    input  logic [N_BINS*WORD_SIZE-1:0]   i_bins_re,
    input  logic [N_BINS*WORD_SIZE-1:0]   i_bins_im,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic signed [WORD_SIZE-1:0]   o_re,
    output logic signed [WORD_SIZE-1:0]   o_im,
    output logic [IDX_W-1:0]              o_idx,
    output logic                          o_last,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [CNT_W-1:0]              o_frame_cnt
);

    import ofdm_pkg::state_t;
    import ofdm_pkg::IDLE;
    import ofdm_pkg::STREAM;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    state_t                       state, state_n;
    logic [IDX_W-1:0]             idx;
    logic                         overflow;
    logic [CNT_W-1:0]             frame_cnt;
    logic                         xfer;
    logic                         final_xfer;
    logic                         capture;
    logic                         drop;
    logic signed [WORD_SIZE-1:0]  rd_re, rd_im;

    // A capture is legal from IDLE, or in the very cycle the last beat leaves.
    always_comb begin
        xfer       = (state == STREAM) && i_ready;
        final_xfer = xfer && (idx == LAST_IDX);
        capture    = i_fft_done && ((state == IDLE) || final_xfer);
        drop       = i_fft_done && (state == STREAM) && !final_xfer;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_fft_done)                state_n = STREAM;
            STREAM:  if (final_xfer && !i_fft_done) state_n = IDLE;
            default:                                state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                idx <= '0;
            end else if (xfer && !final_xfer) begin
                idx <= idx + IDX_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (final_xfer) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    ofdm_bin_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .N_BINS    (N_BINS),
        .IDX_W     (IDX_W)
    ) u_buffer (
        .clk     (i_clk),
        .rst     (i_rst),
        .capture (capture),
        .bins_re (i_bins_re),
        .bins_im (i_bins_im),
        .rd_idx  (idx),
        .rd_re   (rd_re),
        .rd_im   (rd_im)
    );

    // Beat fields are forced to zero outside STREAM so the bus is quiet when idle.
    always_comb begin
        o_valid     = 1'b0;
        o_busy      = 1'b0;
        o_re        = '0;
        o_im        = '0;
        o_idx       = '0;
        o_last      = 1'b0;
        o_overflow  = overflow;
        o_frame_cnt = frame_cnt;
        if (state == STREAM) begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            o_re    = rd_re;
            o_im    = rd_im;
            o_idx   = idx;
            o_last  = (idx == LAST_IDX);
        end
    end

endmodule
